// File: rtl/fpga_serial_bus_if.sv
// fpga_serial_bus_if: per-node frame inputs, transmit request and the serial bus line
interface fpga_serial_bus_if #(
   parameter int NODES  = 16,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 4,
   parameter int CRC_W  = 4
);
   logic [CRC_W-1:0]  crc [NODES];
   logic [DATA_W-1:0] data [NODES];
   logic [ADDR_W-1:0] receiver_addr [NODES];
   logic [NODES-1:0]  mod;
   logic              bus_show;
   modport master (output crc, data, receiver_addr, mod, input bus_show);
   modport slave (input crc, data, receiver_addr, mod, output bus_show);
endinterface

// File: rtl/fpga_serial_bus.sv
// fpga_serial_bus: 16-node single-wire bus, lowest-index arbitration, 77-bit MSB-first frames.
// Optional FPGA_CRC_GEN_EN: send a generated CRC-4 (x^4+x+1) instead of the node's CRC input.
module fpga_serial_bus #(
   parameter int NODES  = 16,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 4,
   parameter int CRC_W  = 4,
   parameter int GAP    = 3
) (
   input logic clock,
   input logic reset,
   fpga_serial_bus_if.slave bus
);
   localparam int HDR_W   = 2 * ADDR_W + DATA_W;
   localparam int FRAME_W = 1 + HDR_W + CRC_W;
   localparam int CNT_W   = $clog2(FRAME_W);
   typedef enum logic [1:0] {IDLE, SEND, GAP_S} state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [FRAME_W-1:0] sr, sr_n, frame;
   logic [HDR_W-1:0] hdr;
   logic [CRC_W-1:0] crc;
   logic bus_q, bus_n, last_v, last_v_n, req;
   logic [ADDR_W-1:0] last_sel, last_n, win;
`ifdef FPGA_CRC_GEN_EN
   function automatic logic [CRC_W-1:0] crc4(input logic [HDR_W-1:0] m);
      logic [CRC_W-1:0] c;
      c = '0;
      for (int i = HDR_W - 1; i >= 0; i--)
         c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ m[i]) ? CRC_W'(4'h3) : '0);
      return c;
   endfunction
`endif
   always_comb begin
      win = '0;
      for (int i = NODES - 1; i >= 0; i--)
         if (bus.mod[i] == 1'b1) win = ADDR_W'(i);
   end
   assign req = bus.mod != '0;
   assign hdr = {win, bus.receiver_addr[win], bus.data[win]};
`ifdef FPGA_CRC_GEN_EN
   assign crc = crc4(hdr);
`else
   assign crc = bus.crc[win];
`endif
   assign frame = {1'b1, hdr, crc};
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      sr_n     = sr;
      bus_n    = 1'b0;
      last_v_n = last_v;
      last_n   = last_sel;
      case (state)
         IDLE: begin
            if (!req) last_v_n = 1'b0;
            else if (!last_v || win != last_sel) begin
               // start bit leaves now; remaining 76 bits wait in the shifter
               sr_n     = {frame[FRAME_W-2:0], 1'b0};
               bus_n    = 1'b1;
               last_v_n = 1'b1;
               last_n   = win;
               cnt_n    = '0;
               state_n  = SEND;
            end
         end
         SEND: begin
            bus_n = sr[FRAME_W-1];
            sr_n  = sr << 1;
            cnt_n = cnt + 1'b1;
            if (cnt == CNT_W'(FRAME_W - 2)) begin
               cnt_n   = '0;
               state_n = GAP_S;
            end
         end
         GAP_S: begin
            if (!req) last_v_n = 1'b0;
            cnt_n = cnt + 1'b1;
            if (cnt == CNT_W'(GAP - 1)) begin
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         sr       <= '0;
         bus_q    <= 1'b0;
         last_v   <= 1'b0;
         last_sel <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         sr       <= sr_n;
         bus_q    <= bus_n;
         last_v   <= last_v_n;
         last_sel <= last_n;
      end
   end
   assign bus.bus_show = bus_q;
endmodule

// File: tb/tb_fpga_serial_bus.sv
// tb_fpga_serial_bus: directed frame checks for fpga_serial_bus
module tb_fpga_serial_bus;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   fpga_serial_bus_if bif ();
   fpga_serial_bus dut (.clock(clock), .reset(reset), .bus(bif));
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // CRC-4 as the remainder of {msg,0000} divided by 10011
   function automatic logic [3:0] ref_crc(input logic [71:0] m);
      logic [75:0] r;
      r = {m, 4'b0};
      for (int i = 75; i >= 4; i--)
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      return r[3:0];
   endfunction

   function automatic logic [76:0] exp_frame(input int n);
      logic [71:0] h;
      logic [3:0] c;
      h = {4'(n), bif.receiver_addr[n], bif.data[n]};
`ifdef FPGA_CRC_GEN_EN
      c = ref_crc(h);
`else
      c = bif.crc[n];
`endif
      return {1'b1, h, c};
   endfunction

   task automatic wait_start(output bit ok);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (bif.bus_show === 1'b1) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic get_bits(inout logic [76:0] f, input int from, input int to);
      for (int k = from; k <= to; k++) begin
         @(negedge clock);
         f[76-k] = bif.bus_show;
      end
   endtask

   task automatic get_frame(input string tag, output logic [76:0] f);
      bit ok;
      wait_start(ok);
      check({tag, "_start"}, 80'(ok), 80'(1));
      f = '0;
      f[76] = 1'b1;
      get_bits(f, 1, 76);
   endtask

   task automatic quiet(input int n, output logic seen);
      seen = 1'b0;
      repeat (n) begin
         @(negedge clock);
         seen = seen | bif.bus_show;
      end
   endtask

   initial begin
      logic [76:0] f, f2;
      logic seen;
      bit ok;
      int gap;
      bif.mod = '0;
      for (int i = 0; i < 16; i++) begin
         bif.data[i] = 64'h0;
         bif.receiver_addr[i] = 4'h0;
         bif.crc[i] = 4'h0;
      end
      bif.data[0] = 64'h1;
      bif.receiver_addr[0] = 4'h1;
      bif.crc[0] = 4'h1;
      bif.data[1] = 64'hDEAD_BEEF_0123_4567;
      bif.receiver_addr[1] = 4'h2;
      bif.crc[1] = 4'h1;
      bif.data[2] = 64'hA5A5_5A5A_F00F_8001;
      bif.receiver_addr[2] = 4'h3;
      bif.crc[2] = 4'h1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_bus", 80'(bif.bus_show), 80'(0));
      reset = 1'b0;
      quiet(5, seen);
      check("idle_mod0", 80'(seen), 80'(0));
      // single frame, held request sends once
      bif.mod = 16'h0001;
      get_frame("t1", f);
`ifndef FPGA_CRC_GEN_EN
      check("t1_frame", 80'(f), 80'({1'b1, 4'h0, 4'h1, 64'h1, 4'h1}));
`else
      check("t1_frame", 80'(f), 80'(exp_frame(0)));
`endif
      quiet(3, seen);
      check("t1_gap", 80'(seen), 80'(0));
      quiet(20, seen);
      check("t1_norepeat", 80'(seen), 80'(0));
      bif.mod = '0;
      quiet(5, seen);
      // sequential nodes
      bif.mod = 16'h0001;
      get_frame("t2a", f);
      check("t2_node1", 80'(f), 80'(exp_frame(0)));
      quiet(10, seen);
      check("t2_hold1", 80'(seen), 80'(0));
      bif.mod = 16'h0002;
      get_frame("t2b", f);
      check("t2_node2", 80'(f), 80'(exp_frame(1)));
      quiet(10, seen);
      bif.mod = 16'h0004;
      get_frame("t2c", f);
      check("t2_node3", 80'(f), 80'(exp_frame(2)));
      bif.mod = '0;
      quiet(30, seen);
      check("t2_after", 80'(seen), 80'(0));
      // priority
      bif.mod = 16'h0006;
      get_frame("t3", f);
      check("t3_node2", 80'(f), 80'(exp_frame(1)));
      quiet(100, seen);
      check("t3_no_node3", 80'(seen), 80'(0));
      bif.mod = '0;
      quiet(5, seen);
      // mid-frame change
      bif.mod = 16'h0001;
      wait_start(ok);
      check("t4_start", 80'(ok), 80'(1));
      f = '0;
      f[76] = 1'b1;
      get_bits(f, 1, 30);
      bif.mod = 16'h0002;
      get_bits(f, 31, 76);
      check("t4_node1", 80'(f), 80'(exp_frame(0)));
      gap = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clock);
         if (bif.bus_show === 1'b1) begin
            gap = n;
            break;
         end
      end
      check("t4_restart_at", 80'(gap), 80'(4));
      f2 = '0;
      f2[76] = 1'b1;
      get_bits(f2, 1, 76);
      check("t4_node2", 80'(f2), 80'(exp_frame(1)));
      bif.mod = '0;
      quiet(5, seen);
      // reset mid-frame
      bif.mod = 16'h0001;
      wait_start(ok);
      check("t5_start", 80'(ok), 80'(1));
      f = '0;
      get_bits(f, 1, 40);
      reset = 1'b1;
      @(negedge clock);
      check("t5_abort", 80'(bif.bus_show), 80'(0));
      reset = 1'b0;
      get_frame("t5", f);
      check("t5_fresh", 80'(f), 80'(exp_frame(0)));
      bif.mod = '0;
      quiet(5, seen);
      // CRC field source: input verbatim, or generated and input ignored
      bif.crc[0] = 4'hF;
      bif.mod = 16'h0001;
      get_frame("t6", f);
`ifdef FPGA_CRC_GEN_EN
      check("t6_crc", 80'(f[3:0]), 80'(ref_crc({4'h0, 4'h1, 64'h1})));
`else
      check("t6_crc", 80'(f[3:0]), 80'(4'hF));
`endif
      check("t6_frame", 80'(f), 80'(exp_frame(0)));
      bif.mod = '0;
      quiet(10, seen);
      check("t6_after", 80'(seen), 80'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
